// File: rtl/rrg_param_loader.sv
// rrg_param_loader
//
// Writer side of the ramp generator's parameter register interface. On a start
// request it latches five 64-bit ramp parameters and the load mask. It then plays
// the selected parameters out on the 16-bit register bus as a timed sequence.
// For each selected item (ascending mask bit) it runs a SETUP state and then a
// WRITE state. SETUP puts the data on reg_3..reg_0 with reg_control = 0. WRITE
// keeps the data and drives the item's select code. The set ends with COMMIT
// (code 5) and a TAIL (code 0). Every state is held HOLD_CYCLES clk cycles, so
// the slower consumer clock can sample each bus state.
//
// Handshake: start is a request sampled only while idle (busy = 0). When it is
// taken, busy rises in the next cycle and stays high until the cycle carrying
// the one-cycle done pulse. A start seen while busy is dropped, not queued.
//
// Ports:
//   clk          fast system clock
//   nReset       asynchronous active-low reset
//   start        single-cycle load request
//   load_mask    bit0 Yset(1), bit1 Rset(2), bit2 RIset(3), bit3 ROset(4),
//                bit4 large_cycle(7)
//   *_in         64-bit parameter values, sampled together with start
//   busy         sequence in progress
//   done         one-cycle pulse in the final cycle of a sequence
//   reg_control  select code to the ramp generator
//   reg_0..reg_3 data words, reg_0 = value[15:0] ... reg_3 = value[63:48]
//   dbg_state    current FSM state, for observation only
//
// All outputs come straight from flops. Next-cycle output values are computed
// from the next state, so nothing combinational reaches the pins.

module rrg_param_loader #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        start,
    input  logic [4:0]  load_mask,
    input  logic [63:0] yset_in,
    input  logic [63:0] rset_in,
    input  logic [63:0] riset_in,
    input  logic [63:0] roset_in,
    input  logic [63:0] cycle_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] reg_control,
    output logic [15:0] reg_0,
    output logic [15:0] reg_1,
    output logic [15:0] reg_2,
    output logic [15:0] reg_3,
    output logic [2:0]  dbg_state
);

    localparam int            CW     = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_WRITE  = 3'd2,
        S_COMMIT = 3'd3,
        S_TAIL   = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    pend, pend_nxt;     // items still to be written
    logic [4:0]    pend_rest;          // pend with the current item removed
    logic [63:0]   val_r   [5];
    logic [63:0]   src_val [5];
    logic [63:0]   data, data_nxt;
    logic [15:0]   ctrl, ctrl_nxt;
    logic          busy_nxt, done_nxt;
    logic [2:0]    item_nxt;

    // Index of the lowest set bit; the current item is always the lowest pending one.
    function automatic logic [2:0] low_idx(input logic [4:0] m);
        low_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (m[i]) low_idx = 3'(i);
        end
    endfunction

    function automatic logic [15:0] item_code(input logic [2:0] idx);
        case (idx)
            3'd0:    item_code = 16'd1;
            3'd1:    item_code = 16'd2;
            3'd2:    item_code = 16'd3;
            3'd3:    item_code = 16'd4;
            3'd4:    item_code = 16'd7;
            default: item_code = 16'd0;
        endcase
    endfunction

    // While idle the first SETUP must present the incoming values directly,
    // because they are only being latched on that same edge.
    always_comb begin
        for (int i = 0; i < 5; i++) src_val[i] = val_r[i];
        if (state == S_IDLE) begin
            src_val[0] = yset_in;
            src_val[1] = rset_in;
            src_val[2] = riset_in;
            src_val[3] = roset_in;
            src_val[4] = cycle_in;
        end
    end

    assign pend_rest = pend & (pend - 5'd1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pend_nxt  = load_mask;
                    cnt_nxt   = RELOAD;
                    state_nxt = (load_mask == 5'd0) ? S_COMMIT : S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = S_WRITE;
                    cnt_nxt   = RELOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_WRITE: begin
                if (cnt == '0) begin
                    pend_nxt  = pend_rest;
                    cnt_nxt   = RELOAD;
                    state_nxt = (pend_rest == 5'd0) ? S_COMMIT : S_SETUP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_COMMIT: begin
                if (cnt == '0) begin
                    state_nxt = S_TAIL;
                    cnt_nxt   = RELOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_TAIL: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output values for the next cycle. Data is loaded only on entry to SETUP
    // and cleared only on return to IDLE. In both cases reg_control is 0 in the
    // new cycle, so a nonzero code is never shown alongside changing data.
    always_comb begin
        item_nxt = low_idx(pend_nxt);
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_TAIL) && (cnt_nxt == '0);
        ctrl_nxt = 16'd0;
        data_nxt = data;
        case (state_nxt)
            S_WRITE:  ctrl_nxt = item_code(item_nxt);
            S_COMMIT: ctrl_nxt = 16'd5;
            default:  ctrl_nxt = 16'd0;
        endcase
        if (state_nxt == S_IDLE) begin
            data_nxt = 64'd0;
        end else if (state_nxt == S_SETUP && state != S_SETUP) begin
            data_nxt = src_val[item_nxt];
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= S_IDLE;
            cnt   <= '0;
            pend  <= '0;
            data  <= '0;
            ctrl  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < 5; i++) val_r[i] <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            data  <= data_nxt;
            ctrl  <= ctrl_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            if (state == S_IDLE && start) begin
                for (int i = 0; i < 5; i++) val_r[i] <= src_val[i];
            end
        end
    end

    assign reg_control = ctrl;
    assign reg_0       = data[15:0];
    assign reg_1       = data[31:16];
    assign reg_2       = data[47:32];
    assign reg_3       = data[63:48];
    assign dbg_state   = state;

endmodule

// File: tb/tb_rrg_param_loader.sv
// Bench for rrg_param_loader. Each request pushes the expected bus segments
// ({reg_control, data}, each HOLD long), the busy-rise cycle and the done cycle.
// A negedge monitor splits the live bus into segments and compares them.

module tb_rrg_param_loader;

    localparam int H = 16;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  load_mask = '0;
    logic [63:0] yset_in = '0, rset_in = '0, riset_in = '0, roset_in = '0, cycle_in = '0;
    logic        busy, done;
    logic [15:0] reg_control, reg_0, reg_1, reg_2, reg_3;
    logic [2:0]  dbg_state;

    rrg_param_loader #(.HOLD_CYCLES(H)) dut (
        .clk(clk), .nReset(nReset), .start(start), .load_mask(load_mask),
        .yset_in(yset_in), .rset_in(rset_in), .riset_in(riset_in),
        .roset_in(roset_in), .cycle_in(cycle_in),
        .busy(busy), .done(done), .reg_control(reg_control),
        .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [79:0] exp_q[$];
    int          exp_start_q[$];
    int          exp_done_q[$];
    logic [63:0] stim_v [5];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_note(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] code16(input int i);
        case (i)
            0:       code16 = 16'd1;
            1:       code16 = 16'd2;
            2:       code16 = 16'd3;
            3:       code16 = 16'd4;
            default: code16 = 16'd7;
        endcase
    endfunction

    // ---------------- monitor ----------------
    logic [63:0] dout;
    logic [79:0] cur;
    assign dout = {reg_3, reg_2, reg_1, reg_0};
    assign cur  = {reg_control, dout};

    bit          run_active = 0;
    logic [79:0] run_val = '0;
    int          run_len = 0;
    logic [63:0] prev_data = '0;
    bit          saw5 = 0;

    task automatic close_run();
        if (exp_q.size() == 0) begin
            fail_note($sformatf("extra_segment %h", run_val));
        end else begin
            check("segment", run_val, exp_q.pop_front());
        end
        check("hold_len", 80'(run_len), 80'(H));
    endtask

    always @(negedge clk) begin
        if (reg_control == 16'd5) saw5 = 1;
        if (!nReset) begin
            run_active = 0;
        end else begin
            if (dout !== prev_data) check("data_change_ctrl0", 80'(reg_control), 80'd0);
            if (done) begin
                check("busy_at_done", 80'(busy), 80'd1);
                if (exp_done_q.size() == 0) fail_note("unexpected_done");
                else check("done_cycle", 80'(cyc), 80'(exp_done_q.pop_front()));
            end
            if (busy) begin
                if (!run_active) begin
                    run_active = 1;
                    run_val    = cur;
                    run_len    = 1;
                    if (exp_start_q.size() == 0) fail_note("unexpected_busy");
                    else check("busy_rise", 80'(cyc), 80'(exp_start_q.pop_front()));
                end else if (cur !== run_val) begin
                    close_run();
                    run_val = cur;
                    run_len = 1;
                end else begin
                    run_len++;
                end
            end else if (run_active) begin
                close_run();
                run_active = 0;
            end
        end
        prev_data = dout;
    end

    // ---------------- driver ----------------
    task automatic rand_stim();
        for (int i = 0; i < 5; i++) stim_v[i] = {$urandom, $urandom};
    endtask

    // Presents one start; with expect_it the reference sequence is queued.
    task automatic issue(input logic [4:0] m, input bit expect_it);
        int          e;
        int          n;
        logic [63:0] last;
        @(negedge clk);
        yset_in   = stim_v[0];
        rset_in   = stim_v[1];
        riset_in  = stim_v[2];
        roset_in  = stim_v[3];
        cycle_in  = stim_v[4];
        load_mask = m;
        start     = 1'b1;
        e = cyc + 1;
        if (expect_it) begin
            last = 64'd0;
            n    = 0;
            for (int i = 0; i < 5; i++) begin
                if (m[i]) begin
                    exp_q.push_back({16'd0, stim_v[i]});
                    exp_q.push_back({code16(i), stim_v[i]});
                    last = stim_v[i];
                    n++;
                end
            end
            exp_q.push_back({16'd5, last});
            exp_q.push_back({16'd0, last});
            exp_start_q.push_back(e);
            exp_done_q.push_back(e + 2 * H * (n + 1) - 1);
        end
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        // Scramble the inputs: they must have no effect while busy.
        yset_in   = {$urandom, $urandom};
        rset_in   = {$urandom, $urandom};
        riset_in  = {$urandom, $urandom};
        roset_in  = {$urandom, $urandom};
        cycle_in  = {$urandom, $urandom};
        load_mask = 5'($urandom_range(0, 31));
    endtask

    task automatic check_drained(input string name);
        check({name, "_segments_left"}, 80'(exp_q.size()), 80'd0);
        check({name, "_done_left"}, 80'(exp_done_q.size()), 80'd0);
    endtask

    task automatic run_seq(input logic [4:0] m, input string name);
        issue(m, 1'b1);
        repeat (2 * H * ($countones(m) + 1) + 3) @(negedge clk);
        check_drained(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("reset_bus", cur, 80'd0);
        check("reset_flags", {78'd0, busy, done}, 80'd0);
        check("reset_state", 80'(dbg_state), 80'd0);
        nReset = 1'b1;
        repeat (2) @(negedge clk);

        // full load
        stim_v[0] = 64'h0000_0001_2345_6789;
        stim_v[1] = 64'h1111_2222_3333_4444;
        stim_v[2] = 64'hAAAA_BBBB_CCCC_DDDD;
        stim_v[3] = 64'h0123_4567_89AB_CDEF;
        stim_v[4] = 64'hFEDC_BA98_7654_3210;
        run_seq(5'b11111, "full");

        // commit only
        rand_stim();
        run_seq(5'b00000, "commit_only");

        // sparse mask
        rand_stim();
        run_seq(5'b10010, "sparse");

        // second start while busy is dropped
        rand_stim();
        issue(5'b11111, 1'b1);
        repeat (48) @(negedge clk);
        rand_stim();
        issue(5'b01101, 1'b0);
        repeat (2 * H * 6) @(negedge clk);
        check_drained("overlap");

        // start coinciding with done is dropped
        rand_stim();
        issue(5'b00001, 1'b1);
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        if (!done) fail_note("done_timeout");
        load_mask = 5'b11111;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("start_at_done_ignored", 80'(busy), 80'd0);
        check_drained("start_at_done");

        // asynchronous reset in the middle of WRITE code 2
        rand_stim();
        issue(5'b00011, 1'b1);
        saw5 = 0;
        for (int i = 0; i < 200 && reg_control != 16'd2; i++) @(negedge clk);
        if (reg_control != 16'd2) fail_note("code2_timeout");
        repeat (3) @(negedge clk);
        #2 nReset = 1'b0;
        #1;
        check("async_reset_bus", cur, 80'd0);
        check("async_reset_flags", {78'd0, busy, done}, 80'd0);
        exp_q.delete();
        exp_start_q.delete();
        exp_done_q.delete();
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_idle", {75'd0, dbg_state, busy, reg_control != 16'd0}, 80'd0);
        check("no_commit_after_reset", 80'(saw5), 80'd0);

        // random masks and values
        for (int t = 0; t < 20; t++) begin
            rand_stim();
            run_seq(5'($urandom_range(0, 31)), "random");
        end

        check_drained("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        fail_note("watchdog");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
